// File: rtl/nnacc_pkg.sv
// Shared types and constants for the NN accelerator NICE memory path.
package nnacc_pkg;

   localparam int CNT_WIDTH = 13;
   localparam int PRM_WIDTH = 4;

   localparam logic [1:0] MIF_IDLE   = 2'b00;
   localparam logic [1:0] MIF_RD_RHS = 2'b01;
   localparam logic [1:0] MIF_RD_LHS = 2'b10;
   localparam logic [1:0] MIF_WR     = 2'b11;

   localparam logic [1:0] SEL_SHIFT = 2'b00;
   localparam logic [1:0] SEL_MULTI = 2'b01;
   localparam logic [1:0] SEL_LBIAS = 2'b10;

   typedef enum logic [2:0] {
      PH_IDLE,
      PH_PRM0,
      PH_PRM1,
      PH_PRM2,
      PH_RHS,
      PH_LHS,
      PH_STORE,
      PH_FIN
   } phase_e;

   // First non-empty phase after cur; the three parameter tables share one length.
   function automatic phase_e phase_after(input phase_e cur,
                                          input logic   prm_nz,
                                          input logic   rhs_nz,
                                          input logic   lhs_nz,
                                          input logic   dst_nz);
      phase_e nxt;
      nxt = PH_FIN;
      case (cur)
         PH_IDLE: begin
            if (prm_nz)      nxt = PH_PRM0;
            else if (rhs_nz) nxt = PH_RHS;
            else if (lhs_nz) nxt = PH_LHS;
            else if (dst_nz) nxt = PH_STORE;
         end
         PH_PRM0: nxt = PH_PRM1;
         PH_PRM1: nxt = PH_PRM2;
         PH_PRM2: begin
            if (rhs_nz)      nxt = PH_RHS;
            else if (lhs_nz) nxt = PH_LHS;
            else if (dst_nz) nxt = PH_STORE;
         end
         PH_RHS: begin
            if (lhs_nz)      nxt = PH_LHS;
            else if (dst_nz) nxt = PH_STORE;
         end
         PH_LHS: begin
            if (dst_nz)      nxt = PH_STORE;
         end
         PH_FIN:  nxt = PH_IDLE;
         default: nxt = PH_FIN;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/memif_word_cnt.sv
// Word index counter shared by all phases; flags the last word of the current length.
module memif_word_cnt #(
   parameter int CNT_W = 13
) (
   input  logic             nice_clk,
   input  logic             nice_rst,
   input  logic             clr,
   input  logic             inc,
   input  logic [CNT_W-1:0] len,
   output logic [CNT_W-1:0] idx,
   output logic             last
);

   always_ff @(posedge nice_clk or posedge nice_rst) begin
      if (nice_rst)
         idx <= '0;
      else if (clr)
         idx <= '0;
      else if (inc)
         idx <= idx + CNT_W'(1);
   end

   assign last = (idx == len - CNT_W'(1));

endmodule

// File: rtl/memif_seq.sv
// Sequencer that walks the NICE memory interface through param, RHS, LHS and store phases.
module memif_seq
   import nnacc_pkg::*;
#(
   parameter int CNT_W = CNT_WIDTH,
   parameter int PRM_W = PRM_WIDTH
) (
   input  logic             nice_clk,
   input  logic             nice_rst,
   input  logic             start,
   input  logic [PRM_W-1:0] prm_len,
   input  logic [CNT_W-1:0] rhs_len,
   input  logic [CNT_W-1:0] lhs_len,
   input  logic [CNT_W-1:0] dst_len,
   input  logic             cmd_ready,
   input  logic             rsp_valid,
   input  logic             rsp_err,
   input  logic             data_in_rdy,
   input  logic             data_out_acq,
   input  logic             st_vld,
   output logic [1:0]       state,
   output logic [31:0]      bias_addr,
   output logic             buf_wr,
   output logic [1:0]       buf_wr_sel,
   output logic             data_in_acq,
   output logic             data_out_rdy,
   output logic             busy,
   output logic             done,
   output logic             err
);

   phase_e           phase_q, phase_d;
   logic             wait_q, wait_d;
   logic             err_q;
   logic [PRM_W-1:0] prm_q;
   logic [CNT_W-1:0] rhs_q, lhs_q, dst_q;
   logic             latch, err_set, err_clr;
   logic             cnt_clr, cnt_inc, cnt_last;
   logic [CNT_W-1:0] cur_len, idx, addr_w;
   logic             rd_phase;

   always_ff @(posedge nice_clk or posedge nice_rst) begin
      if (nice_rst) begin
         phase_q <= PH_IDLE;
         wait_q  <= 1'b0;
         err_q   <= 1'b0;
         prm_q   <= '0;
         rhs_q   <= '0;
         lhs_q   <= '0;
         dst_q   <= '0;
      end else begin
         phase_q <= phase_d;
         wait_q  <= wait_d;
         if (err_set)
            err_q <= 1'b1;
         else if (err_clr)
            err_q <= 1'b0;
         if (latch) begin
            prm_q <= prm_len;
            rhs_q <= rhs_len;
            lhs_q <= lhs_len;
            dst_q <= dst_len;
         end
      end
   end

   assign rd_phase = (phase_q inside {PH_PRM0, PH_PRM1, PH_PRM2, PH_RHS, PH_LHS});

   // Responses are only taken in WAIT, so at most one read is ever outstanding.
   always_comb begin
      phase_d = phase_q;
      wait_d  = wait_q;
      latch   = 1'b0;
      err_set = 1'b0;
      err_clr = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      case (phase_q)
         PH_IDLE: begin
            if (start) begin
               latch   = 1'b1;
               err_clr = 1'b1;
               cnt_clr = 1'b1;
               wait_d  = 1'b0;
               phase_d = phase_after(PH_IDLE, prm_len != '0, rhs_len != '0,
                                     lhs_len != '0, dst_len != '0);
            end
         end
         PH_PRM0, PH_PRM1, PH_PRM2, PH_RHS, PH_LHS: begin
            if (!wait_q) begin
               if (cmd_ready)
                  wait_d = 1'b1;
            end else if (rsp_valid && rsp_err) begin
               err_set = 1'b1;
               cnt_clr = 1'b1;
               wait_d  = 1'b0;
               phase_d = PH_FIN;
            end else if (data_in_rdy) begin
               wait_d = 1'b0;
               if (cnt_last) begin
                  cnt_clr = 1'b1;
                  phase_d = phase_after(phase_q, prm_q != '0, rhs_q != '0,
                                        lhs_q != '0, dst_q != '0);
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         PH_STORE: begin
            if (data_out_acq) begin
               if (cnt_last) begin
                  cnt_clr = 1'b1;
                  phase_d = PH_FIN;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         PH_FIN:  phase_d = PH_IDLE;
         default: phase_d = PH_IDLE;
      endcase
   end

   always_comb begin
      cur_len = '0;
      case (phase_q)
         PH_PRM0, PH_PRM1, PH_PRM2: cur_len = {{(CNT_W-PRM_W){1'b0}}, prm_q};
         PH_RHS:                    cur_len = rhs_q;
         PH_LHS:                    cur_len = lhs_q;
         PH_STORE:                  cur_len = dst_q;
         default:                   cur_len = '0;
      endcase
   end

   memif_word_cnt #(.CNT_W(CNT_W)) u_cnt (
      .nice_clk (nice_clk),
      .nice_rst (nice_rst),
      .clr      (cnt_clr),
      .inc      (cnt_inc),
      .len      (cur_len),
      .idx      (idx),
      .last     (cnt_last)
   );

   // Parameter entries are addressed in the top PRM_W bits of the word index.
   always_comb begin
      state      = MIF_IDLE;
      addr_w     = '0;
      buf_wr     = 1'b0;
      buf_wr_sel = SEL_SHIFT;
      case (phase_q)
         PH_PRM0, PH_PRM1, PH_PRM2: begin
            state  = MIF_RD_RHS;
            buf_wr = 1'b1;
            addr_w = {idx[PRM_W-1:0], {(CNT_W-PRM_W){1'b0}}};
            if (phase_q == PH_PRM1)
               buf_wr_sel = SEL_MULTI;
            else if (phase_q == PH_PRM2)
               buf_wr_sel = SEL_LBIAS;
         end
         PH_RHS: begin
            state  = MIF_RD_RHS;
            addr_w = idx;
         end
         PH_LHS: begin
            state  = MIF_RD_LHS;
            addr_w = idx;
         end
         PH_STORE: begin
            state  = MIF_WR;
            addr_w = idx;
         end
         default: begin
            state  = MIF_IDLE;
            addr_w = '0;
         end
      endcase
   end

   assign bias_addr    = {{(32-CNT_W){1'b0}}, addr_w};
   assign data_in_acq  = rd_phase & ~wait_q;
   assign data_out_rdy = (phase_q == PH_STORE) & st_vld;
   assign busy         = (phase_q != PH_IDLE);
   assign done         = (phase_q == PH_FIN);
   assign err          = err_q;

endmodule

// File: tb/tb_memif_seq.sv
// Directed bench for memif_seq: cycle table for a full transfer plus hand-written corner sequences.
module tb_memif_seq;

   localparam int CNT_W = 13;
   localparam int PRM_W = 4;

   logic             nice_clk, nice_rst;
   logic             start;
   logic [PRM_W-1:0] prm_len;
   logic [CNT_W-1:0] rhs_len, lhs_len, dst_len;
   logic             cmd_ready, rsp_valid, rsp_err, data_in_rdy, data_out_acq, st_vld;
   logic [1:0]       state;
   logic [31:0]      bias_addr;
   logic             buf_wr;
   logic [1:0]       buf_wr_sel;
   logic             data_in_acq, data_out_rdy, busy, done, err;

   int total, bad;
   int grants, done_cnt;
   bit count_en;

   typedef struct {
      logic        start;
      logic        hs;
      logic [1:0]  state;
      logic [31:0] bias;
      logic        buf_wr;
      logic [1:0]  sel;
      logic        acq;
      logic        out_rdy;
      logic        busy;
      logic        done;
   } vec_t;

   vec_t vecs[$];

   memif_seq #(.CNT_W(CNT_W), .PRM_W(PRM_W)) dut (
      .nice_clk     (nice_clk),
      .nice_rst     (nice_rst),
      .start        (start),
      .prm_len      (prm_len),
      .rhs_len      (rhs_len),
      .lhs_len      (lhs_len),
      .dst_len      (dst_len),
      .cmd_ready    (cmd_ready),
      .rsp_valid    (rsp_valid),
      .rsp_err      (rsp_err),
      .data_in_rdy  (data_in_rdy),
      .data_out_acq (data_out_acq),
      .st_vld       (st_vld),
      .state        (state),
      .bias_addr    (bias_addr),
      .buf_wr       (buf_wr),
      .buf_wr_sel   (buf_wr_sel),
      .data_in_acq  (data_in_acq),
      .data_out_rdy (data_out_rdy),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial nice_clk = 1'b0;
   always #5 nice_clk = ~nice_clk;

   // Grants and done pulses are sampled on the edge at which the DUT sees them.
   always @(posedge nice_clk) begin
      if (count_en) begin
         if (data_in_acq && cmd_ready) grants++;
         if (data_out_rdy && data_out_acq) grants++;
         if (done) done_cnt++;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic cr, input logic dr, input logic rv,
                                input logic re, input logic oa, input logic sv);
      start        = st;
      cmd_ready    = cr;
      data_in_rdy  = dr;
      rsp_valid    = rv;
      rsp_err      = re;
      data_out_acq = oa;
      st_vld       = sv;
   endtask

   task automatic setLens(input int p, input int r, input int l, input int d);
      prm_len = PRM_W'(p);
      rhs_len = CNT_W'(r);
      lhs_len = CNT_W'(l);
      dst_len = CNT_W'(d);
   endtask

   task automatic cycle();
      @(posedge nice_clk);
      #1;
   endtask

   task automatic pushRow(input logic [1:0] st, input logic [31:0] ba, input logic bw,
                          input logic [1:0] sel, input logic acq, input logic ordy,
                          input logic bsy, input logic dn);
      vec_t v;
      v.start = 1'b0; v.hs = 1'b1;
      v.state = st; v.bias = ba; v.buf_wr = bw; v.sel = sel;
      v.acq = acq; v.out_rdy = ordy; v.busy = bsy; v.done = dn;
      vecs.push_back(v);
   endtask

   // A read word with immediate handshakes: one REQ cycle then one WAIT cycle.
   task automatic pushWord(input logic [1:0] st, input logic [31:0] ba, input logic bw,
                           input logic [1:0] sel);
      pushRow(st, ba, bw, sel, 1'b1, 1'b0, 1'b1, 1'b0);
      pushRow(st, ba, bw, sel, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic checkVec(input int row, input vec_t v);
      checkOutput($sformatf("row%0d.state", row),   32'(state),        32'(v.state));
      checkOutput($sformatf("row%0d.bias", row),    bias_addr,         v.bias);
      checkOutput($sformatf("row%0d.buf_wr", row),  32'(buf_wr),       32'(v.buf_wr));
      checkOutput($sformatf("row%0d.sel", row),     32'(buf_wr_sel),   32'(v.sel));
      checkOutput($sformatf("row%0d.acq", row),     32'(data_in_acq),  32'(v.acq));
      checkOutput($sformatf("row%0d.out_rdy", row), 32'(data_out_rdy), 32'(v.out_rdy));
      checkOutput($sformatf("row%0d.busy", row),    32'(busy),         32'(v.busy));
      checkOutput($sformatf("row%0d.done", row),    32'(done),         32'(v.done));
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, ".state"},   32'(state),        32'd0);
      checkOutput({tag, ".bias"},    bias_addr,         32'd0);
      checkOutput({tag, ".buf_wr"},  32'(buf_wr),       32'd0);
      checkOutput({tag, ".sel"},     32'(buf_wr_sel),   32'd0);
      checkOutput({tag, ".acq"},     32'(data_in_acq),  32'd0);
      checkOutput({tag, ".out_rdy"}, 32'(data_out_rdy), 32'd0);
      checkOutput({tag, ".busy"},    32'(busy),         32'd0);
      checkOutput({tag, ".done"},    32'(done),         32'd0);
      checkOutput({tag, ".err"},     32'(err),          32'd0);
   endtask

   initial begin
      int acq_cnt;
      bit seen_done;
      logic sv;

      total = 0; bad = 0; grants = 0; done_cnt = 0; count_en = 1'b0;
      nice_rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      setLens(0, 0, 0, 0);

      // Reset values
      repeat (2) @(posedge nice_clk);
      #1;
      checkAllZero("reset");
      nice_rst = 1'b0;
      cycle();
      checkOutput("idle.busy", 32'(busy), 32'd0);

      // Full transfer: prm=2 rhs=3 lhs=2 dst=2, every handshake immediate
      setLens(2, 3, 2, 2);
      pushWord(2'b01, 32'h000, 1'b1, 2'b00);
      vecs[0].start = 1'b1;
      pushWord(2'b01, 32'h200, 1'b1, 2'b00);
      pushWord(2'b01, 32'h000, 1'b1, 2'b01);
      pushWord(2'b01, 32'h200, 1'b1, 2'b01);
      pushWord(2'b01, 32'h000, 1'b1, 2'b10);
      pushWord(2'b01, 32'h200, 1'b1, 2'b10);
      for (int i = 0; i < 3; i++) pushWord(2'b01, 32'(i), 1'b0, 2'b00);
      for (int i = 0; i < 2; i++) pushWord(2'b10, 32'(i), 1'b0, 2'b00);
      pushRow(2'b11, 32'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      pushRow(2'b11, 32'd1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
      pushRow(2'b00, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      pushRow(2'b00, 32'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

      grants = 0; done_cnt = 0; count_en = 1'b1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].start, vecs[i].hs, vecs[i].hs, 1'b0, 1'b0, vecs[i].hs, vecs[i].hs);
         cycle();
         checkVec(i, vecs[i]);
      end
      count_en = 1'b0;
      checkOutput("full.grants", 32'(grants), 32'd13);
      checkOutput("full.done_pulses", 32'(done_cnt), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Only LHS non-empty
      setLens(0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("lhs_only.state", 32'(state), 32'd2);
      checkOutput("lhs_only.bias", bias_addr, 32'd0);
      checkOutput("lhs_only.acq", 32'(data_in_acq), 32'd1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("lhs_only.wait_acq", 32'(data_in_acq), 32'd0);
      checkOutput("lhs_only.wait_state", 32'(state), 32'd2);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("lhs_only.fin_done", 32'(done), 32'd1);
      checkOutput("lhs_only.fin_state", 32'(state), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("lhs_only.idle_busy", 32'(busy), 32'd0);
      checkOutput("lhs_only.idle_done", 32'(done), 32'd0);

      // cmd_ready held low in RHS REQ, then same-cycle cmd_ready/data_in_rdy
      setLens(0, 2, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 0, 1, 0, 0, 0, 0);
         cycle();
         checkOutput($sformatf("stall%0d.acq", i), 32'(data_in_acq), 32'd1);
         checkOutput($sformatf("stall%0d.bias", i), bias_addr, 32'd0);
         checkOutput($sformatf("stall%0d.state", i), 32'(state), 32'd1);
      end
      applyStimulus(0, 1, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("stall.wait_acq", 32'(data_in_acq), 32'd0);
      checkOutput("stall.wait_bias", bias_addr, 32'd0);
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("stall.req1_acq", 32'(data_in_acq), 32'd1);
      checkOutput("stall.req1_bias", bias_addr, 32'd1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("stall.done", 32'(done), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Error on the second RHS response aborts the transfer
      setLens(0, 3, 2, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("err.req1_bias", bias_addr, 32'd1);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 0, 1, 1, 0, 0);
      cycle();
      checkOutput("err.fin_done", 32'(done), 32'd1);
      checkOutput("err.fin_err", 32'(err), 32'd1);
      checkOutput("err.fin_state", 32'(state), 32'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 1, 0, 0, 1, 1);
         cycle();
         checkOutput($sformatf("err.after%0d.state", i), 32'(state), 32'd0);
         checkOutput($sformatf("err.after%0d.busy", i), 32'(busy), 32'd0);
         checkOutput($sformatf("err.after%0d.out_rdy", i), 32'(data_out_rdy), 32'd0);
         checkOutput($sformatf("err.after%0d.err", i), 32'(err), 32'd1);
      end
      setLens(0, 0, 1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("err.restart_err", 32'(err), 32'd0);
      checkOutput("err.restart_state", 32'(state), 32'd2);
      applyStimulus(0, 1, 0, 0, 0, 0, 0);
      cycle();
      applyStimulus(0, 0, 1, 0, 0, 0, 0);
      cycle();
      checkOutput("err.restart_done", 32'(done), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // Asynchronous reset while at STORE index 1
      setLens(0, 0, 0, 3);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("rst.store0_state", 32'(state), 32'd3);
      applyStimulus(0, 0, 0, 0, 0, 1, 1);
      cycle();
      checkOutput("rst.store1_bias", bias_addr, 32'd1);
      checkOutput("rst.store1_rdy", 32'(data_out_rdy), 32'd1);
      done_cnt = 0; count_en = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      nice_rst = 1'b1;
      #1;
      checkAllZero("rst.async");
      repeat (2) @(posedge nice_clk);
      #2;
      nice_rst = 1'b0;
      cycle();
      count_en = 1'b0;
      checkOutput("rst.no_done", 32'(done_cnt), 32'd0);
      checkOutput("rst.idle_busy", 32'(busy), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();

      // st_vld toggling during a 4-word store
      setLens(0, 0, 0, 4);
      applyStimulus(1, 0, 0, 0, 0, 0, 0);
      cycle();
      acq_cnt = 0; seen_done = 1'b0;
      for (int i = 0; i < 20 && !seen_done; i++) begin
         sv = (i % 2 == 0);
         applyStimulus(0, 1, 0, 0, 0, sv, sv);
         #1;
         checkOutput($sformatf("tog%0d.out_rdy", i), 32'(data_out_rdy), 32'(sv));
         if (sv) acq_cnt++;
         cycle();
         if (done) seen_done = 1'b1;
      end
      checkOutput("tog.acq_count", 32'(acq_cnt), 32'd4);
      checkOutput("tog.done_seen", 32'(seen_done), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      cycle();
      checkOutput("tog.idle_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
